weighted_sum_ctrl: RTL and testbench

//  Sequences the vector_scale_add MAC array to compute R = sum_{k=0..NUM_VEC-1} w[k]*X[k].

---
 rtl/weighted_sum_ctrl.sv | 134 +++++++++++++
 tb/tb_weighted_sum_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_sum_ctrl.sv
// rtl/weighted_sum_ctrl.sv - sequences a MAC array to compute R = sum w[k]*X[k]
// Optional abort port and MAC clear enabled by defining WSUM_ABORT_EN.
module weighted_sum_ctrl #(
    parameter int LENGTH      = 5,
    parameter int NUM_VEC     = 11,
    parameter int MAC_LATENCY = 4,
    parameter int IDX_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   rd_en,
    output logic [IDX_W-1:0]       rd_idx,
    input  logic [31:0]            w_in,
    input  logic [32*LENGTH-1:0]   x_in,
    output logic                   mac_ce,
    output logic                   mac_sclr,
    output logic [31:0]            mac_w,
    output logic [32*LENGTH-1:0]   mac_X,
    output logic [64*LENGTH-1:0]   mac_Y,
    input  logic [64*LENGTH-1:0]   p_in,
    output logic [64*LENGTH-1:0]   result,
    output logic                   result_valid,
    input  logic                   result_ready
`ifdef WSUM_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    localparam int CNT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAC_LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] k;
    logic [CNT_W-1:0] cnt;

`ifndef WSUM_ABORT_EN
    assign mac_sclr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            rd_idx       <= '0;
            mac_ce       <= 1'b0;
            mac_w        <= '0;
            mac_X        <= '0;
            mac_Y        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef WSUM_ABORT_EN
            mac_sclr     <= 1'b0;
`endif
        end else begin
`ifdef WSUM_ABORT_EN
            mac_sclr <= 1'b0;
            // Abort wins over every other transition; result keeps its last value.
            if (abort && state != IDLE) begin
                state        <= IDLE;
                busy         <= 1'b0;
                rd_en        <= 1'b0;
                mac_ce       <= 1'b0;
                result_valid <= 1'b0;
                mac_sclr     <= 1'b1;
            end else
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FETCH;
                        k      <= '0;
                        rd_idx <= '0;
                        rd_en  <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                FETCH: begin
                    rd_en <= 1'b0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    // First term starts the chain from zero; later terms add the previous P.
                    mac_w  <= w_in;
                    mac_X  <= x_in;
                    mac_Y  <= (k == '0) ? '0 : p_in;
                    cnt    <= '0;
                    mac_ce <= 1'b1;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == LAST_CNT) begin
                        mac_ce <= 1'b0;
                        if (k == LAST_K) begin
                            result       <= p_in;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            k      <= k + 1'b1;
                            rd_idx <= k + 1'b1;
                            rd_en  <= 1'b1;
                            state  <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weighted_sum_ctrl.sv
// tb/tb_weighted_sum_ctrl.sv - directed self-checking bench for weighted_sum_ctrl
module tb_weighted_sum_ctrl;

    localparam int L = 2;
    localparam logic [127:0] EXP1 = {64'd1062, 64'd532};
    localparam logic [127:0] EXP5 = {64'h00000000FFFFFFFF, 64'hFFFFFFFE00000001};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // three-term instance
    logic         start = 1'b0, result_ready = 1'b1, abort = 1'b0;
    logic         busy, rd_en, mac_ce, mac_sclr, result_valid;
    logic [3:0]   rd_idx;
    logic [31:0]  w_in, mac_w;
    logic [63:0]  x_in, mac_X;
    logic [127:0] mac_Y, p_in, result;

    // single-term instance
    logic         start2 = 1'b0, result_ready2 = 1'b1, abort2 = 1'b0;
    logic         busy2, rd_en2, mac_ce2, mac_sclr2, result_valid2;
    logic [3:0]   rd_idx2;
    logic [31:0]  w_in2, mac_w2;
    logic [63:0]  x_in2, mac_X2;
    logic [127:0] mac_Y2, p_in2, result2;

    int passed = 0;
    int total  = 0;

    weighted_sum_ctrl #(.LENGTH(L), .NUM_VEC(3), .MAC_LATENCY(4), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en), .rd_idx(rd_idx),
        .w_in(w_in), .x_in(x_in), .mac_ce(mac_ce), .mac_sclr(mac_sclr), .mac_w(mac_w),
        .mac_X(mac_X), .mac_Y(mac_Y), .p_in(p_in), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
`ifdef WSUM_ABORT_EN
        , .abort(abort)
`endif
    );

    weighted_sum_ctrl #(.LENGTH(L), .NUM_VEC(1), .MAC_LATENCY(4), .IDX_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .rd_en(rd_en2), .rd_idx(rd_idx2),
        .w_in(w_in2), .x_in(x_in2), .mac_ce(mac_ce2), .mac_sclr(mac_sclr2), .mac_w(mac_w2),
        .mac_X(mac_X2), .mac_Y(mac_Y2), .p_in(p_in2), .result(result2),
        .result_valid(result_valid2), .result_ready(result_ready2)
`ifdef WSUM_ABORT_EN
        , .abort(abort2)
`endif
    );

    // weight ROM / vector store: data one cycle after rd_en
    logic [31:0] wmem [0:3];
    logic [63:0] xmem [0:3];
    initial begin
        wmem[0] = 32'd2; xmem[0] = {32'd1,   32'd1};
        wmem[1] = 32'd3; xmem[1] = {32'd20,  32'd10};
        wmem[2] = 32'd5; xmem[2] = {32'd200, 32'd100};
        wmem[3] = 32'd0; xmem[3] = 64'd0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w_in <= '0; x_in <= '0; w_in2 <= '0; x_in2 <= '0;
        end else begin
            if (rd_en) begin
                w_in <= wmem[rd_idx[1:0]];
                x_in <= xmem[rd_idx[1:0]];
            end
            if (rd_en2) begin
                w_in2 <= 32'hFFFFFFFF;
                x_in2 <= {32'd1, 32'hFFFFFFFF};
            end
        end
    end

    // Behavioural MAC P = A*B + C: the DUT's mac_* registers are the input stage,
    // followed by MAC_LATENCY-1 internal stages advancing on ce.
    function automatic logic [127:0] mac_f(input logic [31:0] a, input logic [63:0] b,
                                           input logic [127:0] c);
        logic [127:0] r;
        for (int i = 0; i < L; i++)
            r[64*i +: 64] = {32'b0, a} * {32'b0, b[32*i +: 32]} + c[64*i +: 64];
        return r;
    endfunction

    logic [127:0] pa0, pa1, pa2, pb0, pb1, pb2;
    assign p_in  = pa2;
    assign p_in2 = pb2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pa0 <= '0; pa1 <= '0; pa2 <= '0; pb0 <= '0; pb1 <= '0; pb2 <= '0;
        end else begin
            if (mac_sclr) begin
                pa0 <= '0; pa1 <= '0; pa2 <= '0;
            end else if (mac_ce) begin
                pa0 <= mac_f(mac_w, mac_X, mac_Y); pa1 <= pa0; pa2 <= pa1;
            end
            if (mac_sclr2) begin
                pb0 <= '0; pb1 <= '0; pb2 <= '0;
            end else if (mac_ce2) begin
                pb0 <= mac_f(mac_w2, mac_X2, mac_Y2); pb1 <= pb0; pb2 <= pb1;
            end
        end
    end

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", rd_en); else passed++;
        total++; if (mac_ce !== 1'b0) $display("FAIL reset_mac_ce: got %0b want 0", mac_ce); else passed++;
        total++; if (mac_sclr !== 1'b0) $display("FAIL reset_mac_sclr: got %0b want 0", mac_sclr); else passed++;
        total++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", result_valid); else passed++;
        total++; if ({result, mac_Y, mac_X, mac_w, rd_idx} !== '0)
            $display("FAIL reset_data: result=%h mac_w=%h want 0", result, mac_w); else passed++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_sum;
        int n;
        result_ready = 1'b1;
        pulse_start();
        total++; if (busy !== 1'b1 || rd_en !== 1'b1 || rd_idx !== 4'd0)
            $display("FAIL sum_fetch0: busy=%0b rd_en=%0b idx=%0d want 1 1 0", busy, rd_en, rd_idx); else passed++;
        wait_valid(n);
        total++; if (n !== 18) $display("FAIL sum_latency: got %0d want 18", n); else passed++;
        total++; if (result !== EXP1) $display("FAIL sum_result: got %h want %h", result, EXP1); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL sum_return: busy=%0b valid=%0b want 0 0", busy, result_valid); else passed++;
    endtask

    task automatic test_backpressure;
        int n;
        int bad;
        bad = 0;
        result_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b1 || result !== EXP1 || busy !== 1'b1) bad++;
        end
        total++; if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); else passed++;
        result_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL hold_release: busy=%0b valid=%0b want 0 0", busy, result_valid); else passed++;
        total++; if (result !== EXP1) $display("FAIL hold_result_kept: got %h want %h", result, EXP1); else passed++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int pulses;
        int c [0:3];
        int ix [0:3];
        cyc = 0; pulses = 0;
        result_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        while (!result_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (rd_en && pulses < 4) begin
                c[pulses] = cyc; ix[pulses] = int'(rd_idx); pulses++;
            end
        end
        // start still high across the handshake edge in DONE
        @(posedge clk); #1; start = 1'b0;
        total++; if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses); else passed++;
        total++; if (pulses == 3 && (ix[0] !== 0 || ix[1] !== 1 || ix[2] !== 2))
            $display("FAIL b2b_idx: got %0d %0d %0d want 0 1 2", ix[0], ix[1], ix[2]); else passed++;
        total++; if (pulses == 3 && (c[1] - c[0] !== 6 || c[2] - c[1] !== 6))
            $display("FAIL b2b_spacing: got %0d %0d want 6 6", c[1] - c[0], c[2] - c[1]); else passed++;
        total++; if (result !== EXP1) $display("FAIL b2b_result: got %h want %h", result, EXP1); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL b2b_done_start_ignored: busy=%0b want 0", busy); else passed++;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || rd_en !== 1'b0)
            $display("FAIL b2b_idle: busy=%0b rd_en=%0b want 0 0", busy, rd_en); else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_start();
        n = 0;
        while (!(mac_ce && rd_idx == 4'd1) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++; if (n >= 50) $display("FAIL rstmid_reach_wait1: got timeout want WAIT of term 1"); else passed++;
        #1; rst = 1'b1; #1;
        total++; if (mac_ce !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || mac_w !== 32'd0)
            $display("FAIL rstmid_clear: ce=%0b busy=%0b valid=%0b mac_w=%h want 0", mac_ce, busy, result_valid, mac_w);
        else passed++;
        @(negedge clk); rst = 1'b0;
        pulse_start();
        wait_valid(n);
        total++; if (n !== 18 || result !== EXP1)
            $display("FAIL rstmid_restart: lat=%0d result=%h want 18 %h", n, result, EXP1); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_term;
        int n;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        n = 0;
        while (!result_valid2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++; if (n !== 6) $display("FAIL single_latency: got %0d want 6", n); else passed++;
        total++; if (result2 !== EXP5) $display("FAIL single_result: got %h want %h", result2, EXP5); else passed++;
        @(posedge clk); #1;
        total++; if (busy2 !== 1'b0) $display("FAIL single_return: busy=%0b want 0", busy2); else passed++;
    endtask

`ifdef WSUM_ABORT_EN
    task automatic test_abort;
        int n;
        int seen;
        logic [127:0] prev;
        prev = result;
        pulse_start();
        n = 0;
        while (!(rd_en && rd_idx == 4'd2) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++; if (n >= 50) $display("FAIL abort_reach_fetch2: got timeout want FETCH of term 2"); else passed++;
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        total++; if (mac_sclr !== 1'b1 || busy !== 1'b0 || mac_ce !== 1'b0)
            $display("FAIL abort_edge: sclr=%0b busy=%0b ce=%0b want 1 0 0", mac_sclr, busy, mac_ce); else passed++;
        total++; if (result !== prev) $display("FAIL abort_result_kept: got %h want %h", result, prev); else passed++;
        @(posedge clk); #1;
        total++; if (mac_sclr !== 1'b0) $display("FAIL abort_sclr_width: got %0b want 0", mac_sclr); else passed++;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) seen++;
        end
        total++; if (seen !== 0) $display("FAIL abort_idle: got %0d active cycles want 0", seen); else passed++;
        pulse_start();
        wait_valid(n);
        total++; if (n !== 18 || result !== EXP1)
            $display("FAIL abort_restart: lat=%0d result=%h want 18 %h", n, result, EXP1); else passed++;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_sum();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_single_term();
`ifdef WSUM_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
